// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo_if
// Description : Valid/ready handshake carrying decoded PS/2 scan codes from
//               the receiver FIFO head to a consumer.
//               master : receiver side (drives valid/code/flags)
//               slave  : consumer side (drives ready)
// Signals     : out_valid   head entry present
//               out_ready   consumer accepts head this cycle
//               out_code    8-bit scan code
//               out_ext     code was preceded by E0
//               out_release code was preceded by F0
// Revision    : 1.0  initial release
// ============================================================================
interface ps2_rx_fifo_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_release;

  modport master (
    output out_valid,
    output out_code,
    output out_ext,
    output out_release,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_code,
    input  out_ext,
    input  out_release,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_fifo
// Description : PS/2 keyboard receiver. Synchronises and glitch-filters the
//               kb_clk/data lines, deframes 11-bit frames (start, 8 data LSB
//               first, odd parity, stop), folds E0/F0 prefixes into flags on
//               the next code and buffers results in a first-word
//               fall-through FIFO popped through a valid/ready handshake.
// Option      : define KB_RX_TIMEOUT_EN to enable the mid-frame watchdog
//               (TIMEOUT_CYC cycles without a falling edge aborts the frame).
// Ports       : clk, rst        system clock, synchronous active-high reset
//               kb_clk, data    asynchronous PS/2 lines
//               out_if          handshake (master): valid/ready/code/ext/release
//               fifo_count      entries stored
//               parity_err      1-cycle pulse, parity check failed
//               frame_err       1-cycle pulse, bad stop bit or timeout
//               overflow        1-cycle pulse, decoded code dropped (FIFO full)
// Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_LEN  = 4,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       kb_clk,
  input  logic                       data,
  ps2_rx_fifo_if.master              out_if,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int c_FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH + 1);

  // --------------------------------------------------------------------------
  // Input synchronisers (reset to idle-high line level)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_kb_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_kb_s;
  logic                   w_data_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kb_sync   <= '1;
      r_data_sync <= '1;
    end else begin
      r_kb_sync   <= {r_kb_sync[SYNC_STAGES-2:0], kb_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data};
    end
  end

  assign w_kb_s   = r_kb_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Clock glitch filter: the filtered level only follows the synced line after
  // FILTER_LEN consecutive disagreeing cycles; any agreement restarts the count.
  // --------------------------------------------------------------------------
  logic                r_filt;
  logic                r_filt_d;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                w_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (w_kb_s != r_filt) begin
        if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
          r_filt     <= w_kb_s;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;

  // --------------------------------------------------------------------------
  // Frame receiver state machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shr;
  logic       r_par_ok;
  logic       r_ext_pend;
  logic       r_rel_pend;
  logic       r_parity_err;
  logic       r_frame_err;
  logic       w_timeout;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_push;
  logic [9:0] w_push_data;

  assign w_is_e0     = (r_shr == 8'hE0);
  assign w_is_f0     = (r_shr == 8'hF0);
  // A clean stop edge on an ordinary code is what feeds the FIFO; prefixes
  // only update the pending flags.
  assign w_push      = w_fall & ~w_timeout & (r_state == S_STOP) & w_data_s &
                       r_par_ok & ~w_is_e0 & ~w_is_f0;
  assign w_push_data = {r_ext_pend, r_rel_pend, r_shr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shr        <= 8'h00;
      r_par_ok     <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_rel_pend   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_rel_pend  <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            // A high data line on a falling edge is not a start bit.
            if (!w_data_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            r_shr     <= {w_data_s, r_shr[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par_ok <= ^{r_shr, w_data_s};
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_data_s) begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_rel_pend  <= 1'b0;
            end else if (!r_par_ok) begin
              r_parity_err <= 1'b1;
              r_ext_pend   <= 1'b0;
              r_rel_pend   <= 1'b0;
            end else if (w_is_e0) begin
              r_ext_pend <= 1'b1;
            end else if (w_is_f0) begin
              r_rel_pend <= 1'b1;
            end else begin
              r_ext_pend <= 1'b0;
              r_rel_pend <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef KB_RX_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Mid-frame watchdog: counts cycles since the last falling edge while a
  // frame is in progress.
  // --------------------------------------------------------------------------
  localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [c_WD_W-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE) || w_fall || w_timeout) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + c_WD_W'(1);
    end
  end

  assign w_timeout = (r_wd == c_WD_W'(TIMEOUT_CYC));
`else
  // Watchdog compiled out; the expression is constant false and only keeps
  // the shared parameter list referenced.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  // --------------------------------------------------------------------------
  // First-word fall-through FIFO
  // --------------------------------------------------------------------------
  logic [9:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_pop   = w_valid & out_if.out_ready;
  // When full, the write slot is only free if the head leaves this cycle.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push & w_full & ~w_pop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields read as zero while empty so outputs are defined from reset.
  assign out_if.out_valid = w_valid;
  assign {out_if.out_ext, out_if.out_release, out_if.out_code} =
      w_valid ? r_mem[r_rd_ptr] : 10'd0;

  assign fifo_count = r_count;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
